// File: rtl/store_merge_rmw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : store_merge_pkg
// Description : Shared store-size encodings and FSM state type for the
//               store read-modify-write block.
// Revision    : 1.0 - initial release
// ============================================================================
package store_merge_pkg;

    // Store size encodings carried on req_funct3
    localparam logic [2:0] C_F3_BYTE   = 3'b000;
    localparam logic [2:0] C_F3_HALF   = 3'b001;
    localparam logic [2:0] C_F3_WORD   = 3'b010;
    localparam logic [2:0] C_F3_DOUBLE = 3'b011;

    // Controller states, explicitly encoded
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/store_merge_rmw_lane_merge.sv
`default_nettype none
// ============================================================================
// Module      : lane_merge
// Description : Combinational byte-lane merge of right-justified store data
//               into an old memory word at a given byte offset.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_merge #(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  old_word,
    input  logic [XLEN-1:0]  data,
    input  logic [OFF_W-1:0] offset,
    input  logic [1:0]       size,
    output logic [XLEN-1:0]  merged
);

    logic [XLEN-1:0] w_lane_mask;
    logic [XLEN-1:0] w_mask_sh;
    logic [XLEN-1:0] w_data_sh;
    logic [OFF_W+2:0] w_shamt;

    // Build a right-justified lane mask for the store size, then move it to the byte offset
    always_comb begin
        w_lane_mask = '1;
        case (size)
            2'd0:    w_lane_mask = XLEN'(8'hFF);
            2'd1:    w_lane_mask = XLEN'(16'hFFFF);
            2'd2:    w_lane_mask = XLEN'(32'hFFFF_FFFF);
            default: w_lane_mask = '1;
        endcase
        w_shamt   = {offset, 3'b000};
        w_mask_sh = w_lane_mask << w_shamt;
        w_data_sh = (data & w_lane_mask) << w_shamt;
        merged    = (old_word & ~w_mask_sh) | w_data_sh;
    end

endmodule
`default_nettype wire

// File: rtl/store_merge_rmw.sv
`default_nettype none
// ============================================================================
// Module      : store_merge_rmw
// Description : Accepts byte/half/word/double stores; full-width aligned
//               stores are written directly, sub-word stores read the old
//               word, merge the new lanes and write it back. Misaligned or
//               illegal sizes are rejected with a one-cycle pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module store_merge_rmw
    import store_merge_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [2:0]        req_funct3,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_valid,
    input  logic [XLEN-1:0]   mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [XLEN-1:0]   mem_wr_data,
    input  logic              mem_wr_ready,
    output logic              done,
    output logic              misaligned
);

    localparam int         OFF_W     = $clog2(XLEN / 8);
    localparam logic [2:0] C_F3_FULL = (XLEN == 64) ? C_F3_DOUBLE : C_F3_WORD;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [XLEN-1:0]   r_data;
    logic [1:0]        r_size;
    logic [XLEN-1:0]   r_wr_data;

    logic [OFF_W-1:0]  w_req_off;
    logic              w_req_legal;
    logic              w_req_full;
    logic              w_accept;
    logic              w_rd_capture;
    logic [XLEN-1:0]   w_merged;
    logic [ADDR_W-1:0] w_addr_aligned;

    assign w_req_off      = req_addr[OFF_W-1:0];
    assign w_addr_aligned = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_accept       = req_valid & req_ready;

    // Classify the incoming request: legal size/alignment, and whether it covers the whole word
    always_comb begin
        w_req_legal = 1'b0;
        case (req_funct3)
            C_F3_BYTE:   w_req_legal = 1'b1;
            C_F3_HALF:   w_req_legal = ~w_req_off[0];
            C_F3_WORD:   w_req_legal = (w_req_off[1:0] == 2'b00);
            C_F3_DOUBLE: w_req_legal = (XLEN == 64) && (w_req_off == '0);
            default:     w_req_legal = 1'b0;
        endcase
        w_req_full = w_req_legal && (req_funct3 == C_F3_FULL);
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and control outputs; everything is forced quiet while reset is high
    always_comb begin
        w_state_nxt  = r_state;
        req_ready    = 1'b0;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        done         = 1'b0;
        misaligned   = 1'b0;
        w_rd_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (!w_req_legal) begin
                        w_state_nxt = ST_ERR;
                    end else if (w_req_full) begin
                        w_state_nxt = ST_WRITE;
                    end else begin
                        w_state_nxt = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                mem_rd_en    = 1'b1;
                w_rd_capture = mem_rd_valid;
                w_state_nxt  = mem_rd_valid ? ST_WRITE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_rd_capture = mem_rd_valid;
                if (mem_rd_valid) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                if (mem_wr_ready) begin
                    done        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ERR: begin
                misaligned  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            req_ready    = 1'b0;
            mem_rd_en    = 1'b0;
            mem_wr_en    = 1'b0;
            done         = 1'b0;
            misaligned   = 1'b0;
            w_rd_capture = 1'b0;
        end
    end

    // Address/data outputs are only driven while their strobe is active, so they read zero in reset
    always_comb begin
        mem_rd_addr = mem_rd_en ? w_addr_aligned : '0;
        mem_wr_addr = mem_wr_en ? w_addr_aligned : '0;
        mem_wr_data = mem_wr_en ? r_wr_data : '0;
    end

    // Request latch and write-data register (direct data for full stores, merged word otherwise)
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_size    <= '0;
            r_wr_data <= '0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_data <= req_data;
                r_size <= req_funct3[1:0];
                if (w_req_full) begin
                    r_wr_data <= req_data;
                end
            end
            if (w_rd_capture) begin
                r_wr_data <= w_merged;
            end
        end
    end

    lane_merge #(
        .XLEN (XLEN)
    ) u_lane_merge (
        .old_word (mem_rd_data),
        .data     (r_data),
        .offset   (r_addr[OFF_W-1:0]),
        .size     (r_size),
        .merged   (w_merged)
    );

endmodule
`default_nettype wire
